// File: rtl/mem_stage_pkg.sv
// Shared widths and the store-buffer entry layout for the MEM stage.
package mem_stage_pkg;
  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 16;
  localparam int RW_DEF    = 3;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_fifo.sv
// In-order store buffer: circular FIFO plus a parallel address lookup that
// returns the youngest matching entry.
module store_buffer_fifo
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  sb_entry_t         push_entry,
  input  logic              pop,
  output sb_entry_t         head,
  output logic              full,
  output logic              empty,
  input  logic [AW_DEF-1:0] lookup_addr,
  output logic              match,
  output logic [DW_DEF-1:0] match_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t         entries [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;
  logic [CW-1:0]     count;

  // Payload storage carries no reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) entries[tail_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = entries[head_ptr];

  // Scan oldest to youngest so the last match (closest to the tail) wins.
  always_comb begin
    logic [PW-1:0] idx;
    match      = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if ((CW'(i) < count) && (entries[idx].addr == lookup_addr)) begin
        match      = 1'b1;
        match_data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/mem_stage_store_buffer.sv
// MEM stage: buffers stores, forwards them to loads, arbitrates the single
// data-memory port and registers the MEM/WB results.
module mem_stage_store_buffer
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  // AW/DW must equal the widths baked into sb_entry_t.
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_mem_read,
  input  logic          in_mem_write,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [DW-1:0] in_alu_result,
  input  logic [RW-1:0] in_dest,
  input  logic          in_reg_write,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_w_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_dest,
  output logic          wb_reg_write,
  output logic          sb_empty
);
  logic          is_load;
  logic          is_store;
  logic          push;
  logic          drain;
  logic          miss;
  logic          hit;
  logic          match;
  logic          full;
  logic          empty;
  logic [DW-1:0] match_data;
  logic [DW-1:0] load_data;
  sb_entry_t     head;
  sb_entry_t     push_entry;

  // Handshake: the MEM instruction is consumed at the rising edge when
  // in_valid & ~stall; while stall is high upstream holds every in_* input.
  assign is_load    = in_valid & in_mem_read;
  assign is_store   = in_valid & in_mem_write;
  assign stall      = is_store & full;
  assign push       = is_store & ~full;
  assign hit        = is_load & match;
  assign miss       = is_load & ~match;
  assign drain      = ~miss & ~empty;
  assign push_entry = '{addr: in_addr, data: in_wdata};
  assign load_data  = hit ? match_data : mem_rdata;
  assign sb_empty   = empty;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (drain),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .lookup_addr (in_addr),
    .match       (match),
    .match_data  (match_data)
  );

  // A missing load owns the port; otherwise the head drains whenever present.
  always_comb begin
    mem_addr  = in_addr;
    mem_wdata = '0;
    mem_w_en  = 1'b0;
    if (drain) begin
      mem_addr  = head.addr;
      mem_wdata = head.data;
      mem_w_en  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_dest      <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid     <= in_valid & ~stall;
      wb_data      <= in_mem_read ? load_data : in_alu_result;
      wb_dest      <= in_dest;
      wb_reg_write <= in_valid & ~stall & in_reg_write & ~in_mem_write;
    end
  end
endmodule

// File: tb/tb_mem_stage_store_buffer.sv
// Directed plus random bench for mem_stage_store_buffer with a 64x16 data
// memory model and a queue-based store-buffer reference.
module tb_mem_stage_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write;
  logic [7:0]  in_addr;
  logic [15:0] in_wdata, in_alu_result;
  logic [2:0]  in_dest;
  logic        stall, mem_w_en, wb_valid, wb_reg_write, sb_empty;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata, wb_data;
  logic [2:0]  wb_dest;

  int checks   = 0;
  int failures = 0;

  logic [19:0] exp_q[$];   // {dest, reg_write, data} per accepted instruction
  logic [23:0] sb_q[$];    // reference store buffer {addr, data}
  logic [15:0] ref_mem [64];
  logic [15:0] dmem [64];
  logic        mem_init;

  always #5 clk = ~clk;

  mem_stage_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_alu_result(in_alu_result), .in_dest(in_dest), .in_reg_write(in_reg_write),
    .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_reg_write(wb_reg_write), .sb_empty(sb_empty)
  );

  // Data memory: combinational read, write on the falling edge.
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= (i == 7) ? 16'h1234 : 16'h0000;
    end else if (mem_w_en) begin
      dmem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = dmem[mem_addr[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every wb_valid cycle pops the oldest expected result.
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst === 1'b0 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_dest", 32'(wb_dest), 32'(e[19:17]));
        check("wb_reg_write", 32'(wb_reg_write), 32'(e[16]));
        check("wb_data", 32'(wb_data), 32'(e[15:0]));
      end
    end
  end

  task automatic drive_idle();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
    in_addr = '0; in_wdata = '0; in_alu_result = '0; in_dest = '0;
  endtask

  // One MEM cycle: called just after a rising edge, returns just after the next.
  task automatic step(input logic v, input logic rd, input logic wr, input logic [7:0] a,
                      input logic [15:0] wd, input logic [15:0] alu, input logic [2:0] d,
                      input logic rw, output logic stalled);
    logic        hit_m, full_m, stall_m, miss_m, drain_m;
    logic [15:0] fwd_m, ld_m;
    logic [23:0] h;
    in_valid = v; in_mem_read = rd; in_mem_write = wr; in_addr = a;
    in_wdata = wd; in_alu_result = alu; in_dest = d; in_reg_write = rw;
    hit_m = 0; fwd_m = '0;
    foreach (sb_q[i]) if (sb_q[i][23:16] == a) begin hit_m = 1; fwd_m = sb_q[i][15:0]; end
    full_m  = (sb_q.size() == DEPTH);
    stall_m = v & wr & full_m;
    miss_m  = v & rd & ~hit_m;
    drain_m = ~miss_m & (sb_q.size() != 0);
    ld_m    = hit_m ? fwd_m : ref_mem[a[5:0]];
    @(negedge clk);
    check("stall", 32'(stall), 32'(stall_m));
    check("mem_w_en", 32'(mem_w_en), 32'(drain_m));
    check("sb_empty", 32'(sb_empty), 32'(sb_q.size() == 0));
    if (drain_m) begin
      h = sb_q.pop_front();
      check("drain_addr", 32'(mem_addr), 32'(h[23:16]));
      check("drain_data", 32'(mem_wdata), 32'(h[15:0]));
      ref_mem[h[21:16]] = h[15:0];
    end else if (miss_m) begin
      check("load_addr", 32'(mem_addr), 32'(a));
    end else begin
      check("idle_wdata", 32'(mem_wdata), 32'd0);
    end
    #1;
    if (v && !stall_m) exp_q.push_back({d, rw & ~wr, (rd ? ld_m : alu)});
    if (v && wr && !stall_m) sb_q.push_back({a, wd});
    @(posedge clk); #1;
    stalled = stall_m;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [15:0] wd, input logic [15:0] alu,
                       input logic [2:0] d, input logic rw);
    logic st;
    int   n;
    n = 0;
    st = 1;
    while (st && n < 10) begin
      step(1'b1, rd, wr, a, wd, alu, d, rw, st);
      n++;
    end
    if (st) check("stall_bound", 32'(st), 32'd0);
  endtask

  task automatic idle(input int n);
    logic st;
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'd0, 16'd0, 16'd0, 3'd0, 0, st);
  endtask

  initial begin
    logic [1:0] op;
    rst = 1; mem_init = 1;
    drive_idle();
    for (int i = 0; i < 64; i++) ref_mem[i] = (i == 7) ? 16'h1234 : 16'h0000;
    @(negedge clk); #1;
    mem_init = 0;
    check("rst_sb_empty", 32'(sb_empty), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_dest", 32'(wb_dest), 32'd0);
    check("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst_mem_w_en", 32'(mem_w_en), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Single store drains one cycle later, for exactly one cycle.
    issue(0, 1, 8'd5, 16'h00AA, 16'h0005, 3'd0, 0);
    idle(3);

    // Same-address stores then a load: youngest value forwards.
    issue(0, 1, 8'd3, 16'h0011, 16'h0000, 3'd1, 0);
    issue(0, 1, 8'd3, 16'h0022, 16'h0000, 3'd1, 0);
    issue(1, 0, 8'd3, 16'h0000, 16'h0000, 3'd2, 1);
    idle(2);
    check("mem3_final", 32'(dmem[3]), 32'h0022);

    // Stores to 10..14 interleaved with missing loads that hold the port.
    for (int i = 0; i < 5; i++) begin
      issue(0, 1, 8'(10 + i), 16'(16'h0100 + i), 16'h0000, 3'd0, 0);
      issue(1, 0, 8'd40, 16'h0000, 16'h0000, 3'd3, 1);
    end
    idle(2);

    // Load misses on preset memory while a store is buffered.
    issue(0, 1, 8'd20, 16'h5555, 16'h0000, 3'd0, 0);
    issue(1, 0, 8'd7, 16'h0000, 16'h0000, 3'd4, 1);
    idle(2);

    // Non-memory instruction alongside a drain.
    issue(0, 1, 8'd21, 16'h6666, 16'h0000, 3'd0, 0);
    issue(0, 0, 8'd0, 16'h0000, 16'hBEEF, 3'd6, 1);
    idle(2);

    // Random mix over a small address set to exercise hits and pointer wrap.
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom_range(0, 3));
      case (op)
        2'd0: idle(1);
        2'd1: issue(0, 1, 8'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        2'd2: issue(1, 0, 8'($urandom_range(0, 7)), 16'd0, 16'($urandom),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        default: issue(0, 0, 8'($urandom_range(0, 63)), 16'd0, 16'($urandom),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      endcase
    end
    idle(3);

    // Reset mid-cycle with a store still buffered: it must never reach memory.
    issue(0, 1, 8'd50, 16'h7777, 16'h0000, 3'd0, 0);
    #2 rst = 1;
    #1;
    check("midrst_sb_empty", 32'(sb_empty), 32'd1);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    check("midrst_mem_w_en", 32'(mem_w_en), 32'd0);
    sb_q.delete();
    exp_q.delete();
    @(negedge clk); #1;
    check("midrst_mem50", 32'(dmem[50]), 32'(ref_mem[50]));
    @(posedge clk); #1;
    rst = 0;
    idle(3);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 64; i++) check("mem_final", 32'(dmem[i]), 32'(ref_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
